fir_sample_feeder: RTL and testbench
====================================

// Module: fir_sample_feeder
// PURPOSE
//  Transmit side of the fir8 sample-stream interface: buffers samples from an ADC/host writer in a FIFO
//  and drives sample/valid into fir8 (sample_in/valid_in), honouring fir8's ready_in.
//  Paces output at one sample per RATE_DIV cycles, primes the FIFO before streaming, and reports
//  overflow/underrun so the filter sees a clean, rate-controlled Q1.15 stream.
// PARAMETERS
//  DEPTH     16  FIFO entries; power of 2, 4..256
//  RATE_DIV   1  cycles per output slot; 1 = every cycle, max 65535
//  PRIME_LVL  4  FIFO level required to leave PRIME; 1..DEPTH
// PORTS
//  clk         in   1              system clock
//  rst         in   1              synchronous, active-high reset
//  enable      in   1              1 = stream, 0 = halt after current output accepted
//  flush       in   1              1-cycle pulse: empty FIFO (output register untouched)
//  wr_data     in   16 (signed)    Q1.15 sample from writer
//  wr_en       in   1              push wr_data
//  wr_full     out  1              level == DEPTH
//  level       out  $clog2(DEPTH)+1  FIFO occupancy
//  sample_out  out  16 (signed)    to fir8 sample_in
//  valid_out   out  1              to fir8 valid_in
//  ds_ready    in   1              from fir8 ready_in
//  overflow    out  1              sticky: write dropped at full
//  underrun    out  16             saturating count of empty output slots in STREAM
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, FIFO empty, level=0, wr_full=0, valid_out=0, sample_out=0,
//   overflow=0, underrun=0, rate counter=0, slot pending=0. Reset mid-stream discards all data.
//  Write: wr_en & !wr_full pushes; wr_en & wr_full drops the sample and sets overflow. wr_full uses the
//   registered level, so a write at full is dropped even if a pop occurs in the same cycle.
//  Push and pop in the same cycle (not full): level unchanged. Pointers wrap mod DEPTH.
//  flush: level=0, pointers equal; a same-cycle write is discarded; flush wins over push/pop.
//  Handshake: transfer = valid_out & ds_ready. Once asserted, valid_out and sample_out hold until
//   transfer. Output register is free if !valid_out or transfer this cycle.
//  FSM (registered transitions):
//   IDLE   -> PRIME when enable=1.
//   PRIME  -> STREAM when level >= PRIME_LVL; -> IDLE when enable=0. No pops, no ticks.
//   STREAM -> IDLE when enable=0; the held valid_out remains until transfer, with no new loads.
//  Rate counter: cleared on STREAM entry, counts 0..RATE_DIV-1 in STREAM; tick when count==0,
//   so the first tick falls in the first STREAM cycle. Tick sets slot pending.
//  Slot service (STREAM, pending|tick, output free): FIFO non-empty -> pop head into sample_out,
//   valid_out=1 next cycle; FIFO empty -> underrun += 1 (saturates at 65535), valid_out=0.
//   Either case clears pending. If the output is not free, pending holds; at most one slot pends
//   (extra ticks merge and are not counted).
//  Latency: with STREAM, RATE_DIV=1 and ds_ready=1, a word pushed into an empty FIFO at cycle t
//   appears on sample_out/valid_out at t+2. Sustained throughput is 1 sample per max(RATE_DIV,1) cycles.
//  No arithmetic on samples: bit-exact pass-through, FIFO order preserved.
// TESTING
//  1 Reset: rst high 2 cycles with wr_en=1 -> all outputs 0, level=0, nothing stored.
//  2 Prime+stream: PRIME_LVL=4, push 1,2,3,4 with enable=1 and ds_ready=1 -> valid_out starts only after
//    level=4; outputs 1,2,3,4 on consecutive cycles, then underrun increments each cycle while empty.
//  3 Pacing: RATE_DIV=4, 8 samples pre-loaded, ds_ready=1 -> valid_out pulses every 4th cycle,
//    values in order, underrun=0.
//  4 Backpressure: hold ds_ready=0 for 10 cycles mid-stream -> sample_out stable (e.g. 0x7FFF),
//    valid_out=1; after release exactly one sample transfers per slot, none lost or duplicated.
//  5 Overflow: DEPTH=16, no pops, push 17 words -> wr_full=1 after 16, 17th dropped, overflow=1 sticky
//    until rst; read-back gives words 1..16.
//  6 Halt/flush: enable=0 while valid_out=1, ds_ready=0 -> valid_out holds until transfer, then 0 and
//    state IDLE; flush with level=5 -> level=0 next cycle.

Source files
------------

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: FIFO-buffered, rate-paced Q1.15 sample source for the fir8 stream input.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_enable            1 = stream, 0 = halt once the held output is accepted
//   i_flush             1-cycle pulse that empties the FIFO (output register untouched)
//   i_wr_data, i_wr_en  writer side; o_wr_full / o_level report occupancy
//   o_sample_out,
//   o_valid_out,
//   i_ds_ready          valid/ready handshake into fir8
//   o_overflow          sticky: a write was dropped at full
//   o_underrun          saturating count of output slots that found the FIFO empty
module fir_sample_feeder #(
   parameter int DEPTH     = 16,
   parameter int RATE_DIV  = 1,
   parameter int PRIME_LVL = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_enable,
   input  logic                      i_flush,
   input  logic signed [15:0]        i_wr_data,
   input  logic                      i_wr_en,
   output logic                      o_wr_full,
   output logic [$clog2(DEPTH):0]    o_level,
   output logic signed [15:0]        o_sample_out,
   output logic                      o_valid_out,
   input  logic                      i_ds_ready,
   output logic                      o_overflow,
   output logic [15:0]               o_underrun
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;
   state_t             r_state;
   logic signed [15:0] r_mem [DEPTH];
   logic [AW-1:0]      r_wp, r_rp;
   logic [AW:0]        r_level;
   logic [15:0]        r_cnt;
   logic               r_pend;
   logic signed [15:0] r_sample;
   logic               r_valid;
   logic               r_ovf;
   logic [15:0]        r_und;
   logic               w_full, w_empty, w_xfer, w_free, w_stream, w_tick, w_service, w_push, w_pop;
   assign w_full    = r_level == (AW+1)'(DEPTH);
   assign w_empty   = r_level == '0;
   assign w_xfer    = r_valid && i_ds_ready;
   assign w_free    = !r_valid || w_xfer;
   // Gating on i_enable stops new loads in the cycle the halt is requested.
   assign w_stream  = r_state == STREAM && i_enable;
   assign w_tick    = w_stream && r_cnt == '0;
   // A flush cycle defers slot service so the head is never popped while being discarded.
   assign w_service = w_stream && (r_pend || w_tick) && w_free && !i_flush;
   assign w_pop     = w_service && !w_empty;
   assign w_push    = i_wr_en && !w_full && !i_flush;
   assign o_wr_full    = w_full;
   assign o_level      = r_level;
   assign o_sample_out = r_sample;
   assign o_valid_out  = r_valid;
   assign o_overflow   = r_ovf;
   assign o_underrun   = r_und;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_wp     <= '0;
         r_rp     <= '0;
         r_level  <= '0;
         r_cnt    <= '0;
         r_pend   <= 1'b0;
         r_sample <= '0;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
         r_und    <= '0;
      end else begin
         r_state <= !i_enable ? IDLE :
                    r_state == IDLE ? PRIME :
                    (r_state == PRIME && r_level >= (AW+1)'(PRIME_LVL)) ? STREAM : r_state;
         // Counter idles at zero outside STREAM, so the first STREAM cycle always ticks.
         r_cnt   <= (r_state == STREAM && r_cnt != 16'(RATE_DIV - 1)) ? r_cnt + 16'd1 : '0;
         // One pending slot at most: extra ticks while blocked merge into it.
         r_pend  <= w_stream && !w_service && (r_pend || w_tick);
         r_wp    <= i_flush ? '0 : r_wp + AW'(w_push);
         r_rp    <= i_flush ? '0 : r_rp + AW'(w_pop);
         r_level <= i_flush ? '0 : r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
         if (w_pop) begin
            r_sample <= r_mem[r_rp];
            r_valid  <= 1'b1;
         end else if (w_xfer) begin
            r_valid  <= 1'b0;
         end
         r_ovf <= r_ovf || (i_wr_en && w_full);
         if (w_service && w_empty && r_und != 16'hFFFF)
            r_und <= r_und + 16'd1;
      end
   end
   // Storage needs no reset: reset and flush clear the pointers, which discards contents.
   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_wp] <= i_wr_data;
   end
endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: scoreboard plus table-driven bench for fir_sample_feeder.
module tb_fir_sample_feeder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] wr_data = '0;
   logic        wr_en = 1'b0;
   logic        ds_ready = 1'b0;
   logic        full, vout, ovf;
   logic [4:0]  level;
   logic [15:0] sout, und;
   logic        p_full, p_vout, p_ovf;
   logic [4:0]  p_level;
   logic [15:0] p_sout, p_und;
   int          checks = 0;
   int          failures = 0;
   logic [15:0] sb [$];
   typedef struct {
      logic        we;
      logic [15:0] d;
      logic        trk;
      logic [4:0]  lvl;
      logic        full;
      logic        ovf;
   } vec_t;
   vec_t tbl [18];

   always #5 clk = ~clk;

   fir_sample_feeder #(.DEPTH(16), .RATE_DIV(1), .PRIME_LVL(4)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_flush(flush),
      .i_wr_data(wr_data), .i_wr_en(wr_en), .o_wr_full(full), .o_level(level),
      .o_sample_out(sout), .o_valid_out(vout), .i_ds_ready(ds_ready),
      .o_overflow(ovf), .o_underrun(und));

   fir_sample_feeder #(.DEPTH(16), .RATE_DIV(4), .PRIME_LVL(4)) u_pace (
      .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_flush(flush),
      .i_wr_data(wr_data), .i_wr_en(wr_en), .o_wr_full(p_full), .o_level(p_level),
      .o_sample_out(p_sout), .o_valid_out(p_vout), .i_ds_ready(ds_ready),
      .o_overflow(p_ovf), .o_underrun(p_und));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Transfers happen at the next posedge; sample them mid-cycle against the scoreboard.
   task automatic mon();
      if (!rst && vout && ds_ready) begin
         if (sb.size() == 0) chk("sb_extra", sb.size(), 1);
         else chk("sb_data", sout, sb.pop_front());
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] d, input bit trk);
      wr_en = 1'b1;
      wr_data = d;
      if (trk) sb.push_back(d);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wr_en = 1'b1;
      wr_data = 16'h1234;
      enable = 1'b0;
      flush = 1'b0;
      ds_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      wr_en = 1'b0;
      sb.delete();
   endtask

   task automatic wait_valid(input string nm);
      int n = 0;
      while (!vout && n < 20) begin
         tick();
         n++;
      end
      chk(nm, vout, 1);
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (sb.size() > 0 && n < 60) begin
         tick();
         n++;
      end
      chk(nm, sb.size(), 0);
   endtask

   initial begin
      int n;
      int last;
      for (int i = 0; i < 18; i++) begin
         tbl[i].we   = i < 17;
         tbl[i].d    = 16'(i + 1);
         tbl[i].trk  = i < 16;
         tbl[i].lvl  = 5'(i < 16 ? i + 1 : 16);
         tbl[i].full = i >= 15;
         tbl[i].ovf  = i >= 16;
      end
      @(posedge clk);
      #1;

      do_reset();
      chk("rst_level", level, 0);
      chk("rst_full", full, 0);
      chk("rst_valid", vout, 0);
      chk("rst_sample", sout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_und", und, 0);
      chk("rst_p_level", p_level, 0);

      enable = 1'b1;
      ds_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         wr(16'(k), 1'b1);
         chk("prime_valid", vout, 0);
         chk("prime_level", level, k);
      end
      wait_valid("prime_start");
      for (int k = 1; k <= 4; k++) begin
         chk("stream_data", sout, k);
         chk("stream_valid", vout, 1);
         tick();
      end
      for (int u = 1; u <= 3; u++) begin
         chk("underrun_cnt", und, u);
         chk("underrun_valid", vout, 0);
         tick();
      end
      enable = 1'b0;
      tick();

      do_reset();
      ds_ready = 1'b1;
      for (int i = 0; i < 8; i++) wr(16'h0100 + 16'(i), 1'b1);
      chk("pace_preload", p_level, 8);
      enable = 1'b1;
      n = 0;
      last = 0;
      for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
         if (p_vout) begin
            chk("pace_data", p_sout, 16'h0100 + 16'(n));
            if (n > 0) chk("pace_gap", cyc - last, 4);
            chk("pace_und", p_und, 0);
            last = cyc;
            n++;
         end
         tick();
      end
      chk("pace_count", n, 8);
      drain("pace_drain");
      enable = 1'b0;
      tick();

      do_reset();
      enable = 1'b1;
      wr(16'h7FFF, 1'b1);
      wr(16'h0001, 1'b1);
      wr(16'h8000, 1'b1);
      wr(16'h1234, 1'b1);
      wr(16'h5555, 1'b1);
      wait_valid("bp_start");
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold_valid", vout, 1);
         chk("bp_hold_data", sout, 16'h7FFF);
         tick();
      end
      chk("bp_level", level, 4);
      chk("bp_und", und, 0);
      ds_ready = 1'b1;
      drain("bp_drain");
      enable = 1'b0;
      tick();

      do_reset();
      ds_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         if (tbl[i].we) wr(tbl[i].d, tbl[i].trk);
         else tick();
         chk("ovf_level", level, tbl[i].lvl);
         chk("ovf_full", full, tbl[i].full);
         chk("ovf_flag", ovf, tbl[i].ovf);
      end
      enable = 1'b1;
      drain("ovf_readback");
      chk("ovf_sticky", ovf, 1);
      enable = 1'b0;
      tick();
      do_reset();
      chk("ovf_rst_clear", ovf, 0);

      enable = 1'b1;
      wr(16'h0A0A, 1'b1);
      wr(16'h0B0B, 1'b0);
      wr(16'h0C0C, 1'b0);
      wr(16'h0D0D, 1'b0);
      wr(16'h0E0E, 1'b0);
      wait_valid("halt_start");
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("halt_valid", vout, 1);
         chk("halt_data", sout, 16'h0A0A);
         chk("halt_und", und, 0);
      end
      ds_ready = 1'b1;
      tick();
      chk("halt_released", vout, 0);
      chk("halt_level", level, 4);
      tick();
      tick();
      chk("halt_no_load", vout, 0);
      chk("halt_level2", level, 4);
      wr(16'h0F0F, 1'b0);
      chk("flush_pre_level", level, 5);
      flush = 1'b1;
      wr_en = 1'b1;
      wr_data = 16'h1111;
      tick();
      flush = 1'b0;
      wr_en = 1'b0;
      chk("flush_level", level, 0);
      chk("flush_full", full, 0);
      enable = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("flush_empty_valid", vout, 0);
      chk("flush_sb", sb.size(), 0);
      enable = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
